// File: rtl/wbi_slave_bridge.sv
// wbi_slave_bridge: last node of the Wishbone daisy chain. Turns the
// valid/ready command stream into a single-burst Wishbone transaction on the
// slave bus and returns every slave acknowledge, tagged with its TID, on the
// valid/ready response stream. Only one burst is in flight at a time.
module wbi_slave_bridge #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned BW = 4,
   parameter int unsigned BL = 10
) (
   input  logic          mclk,
   input  logic          reset_n,
   // command stream from the staging stage
   input  logic          wbd_cmd_wval_i,
   output logic          wbd_cmd_wrdy_o,
   input  logic [AW-1:0] wbd_cmd_adr_i,
   input  logic          wbd_cmd_we_i,
   input  logic [DW-1:0] wbd_cmd_dat_i,
   input  logic [BW-1:0] wbd_cmd_sel_i,
   input  logic [3:0]    wbd_cmd_tid_i,
   input  logic [BL-1:0] wbd_cmd_bl_i,
   // response stream back up the chain
   output logic          wbd_res_rval_o,
   input  logic          wbd_res_rrdy_i,
   output logic [DW-1:0] wbd_res_dat_o,
   output logic          wbd_res_ack_o,
   output logic          wbd_res_lack_o,
   output logic          wbd_res_err_o,
   output logic [3:0]    wbd_res_tid_o,
   // slave bus
   output logic          wbs_cyc_o,
   output logic          wbs_stb_o,
   output logic          wbs_we_o,
   output logic [AW-1:0] wbs_adr_o,
   output logic [DW-1:0] wbs_dat_o,
   output logic [BW-1:0] wbs_sel_o,
   output logic [BL-1:0] wbs_bl_o,
   output logic          wbs_bry_o,
   input  logic [DW-1:0] wbs_dat_i,
   input  logic          wbs_ack_i,
   input  logic          wbs_lack_i,
   input  logic          wbs_err_i
);

   typedef enum logic [2:0] {IDLE, RD, WR, WR_WAIT, DRAIN} state_t;

   state_t        state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic [BW-1:0] sel_q, sel_d;
   logic [BL-1:0] bl_q, bl_d;
   logic [3:0]    tid_q, tid_d;
   logic [BL-1:0] cnt_q, cnt_d;
   logic          rspFull_q, rspFull_d;
   logic [DW-1:0] rspDat_q, rspDat_d;
   logic          rspAck_q, rspAck_d;
   logic          rspLack_q, rspLack_d;
   logic          rspErr_q, rspErr_d;
   logic [3:0]    rspTid_q, rspTid_d;

   logic          rspLoad;
   logic          lastBeat;
   logic [DW-1:0] loadDat;

   // State and datapath registers; reset aborts any burst and drops the response.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         bl_q      <= '0;
         tid_q     <= '0;
         cnt_q     <= '0;
         rspFull_q <= 1'b0;
         rspDat_q  <= '0;
         rspAck_q  <= 1'b0;
         rspLack_q <= 1'b0;
         rspErr_q  <= 1'b0;
         rspTid_q  <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         bl_q      <= bl_d;
         tid_q     <= tid_d;
         cnt_q     <= cnt_d;
         rspFull_q <= rspFull_d;
         rspDat_q  <= rspDat_d;
         rspAck_q  <= rspAck_d;
         rspLack_q <= rspLack_d;
         rspErr_q  <= rspErr_d;
         rspTid_q  <= rspTid_d;
      end
   end

   // Next-state logic: burst sequencing, beat counting and response loading.
   // An error or last ack ends the burst; a write cut short drains its leftover beats.
   always_comb begin
      state_d        = state_q;
      cyc_d          = cyc_q;
      stb_d          = stb_q;
      we_d           = we_q;
      adr_d          = adr_q;
      dat_d          = dat_q;
      sel_d          = sel_q;
      bl_d           = bl_q;
      tid_d          = tid_q;
      cnt_d          = cnt_q;
      rspFull_d      = rspFull_q;
      rspDat_d       = rspDat_q;
      rspAck_d       = rspAck_q;
      rspLack_d      = rspLack_q;
      rspErr_d       = rspErr_q;
      rspTid_d       = rspTid_q;
      wbd_cmd_wrdy_o = 1'b0;
      wbs_bry_o      = 1'b0;
      rspLoad        = 1'b0;
      loadDat        = '0;
      lastBeat       = (cnt_q == BL'(1)) || wbs_lack_i || wbs_err_i;

      if (rspFull_q && wbd_res_rrdy_i) begin
         rspFull_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            wbd_cmd_wrdy_o = 1'b1;
            if (wbd_cmd_wval_i) begin
               adr_d   = wbd_cmd_adr_i;
               we_d    = wbd_cmd_we_i;
               dat_d   = wbd_cmd_dat_i;
               sel_d   = wbd_cmd_sel_i;
               tid_d   = wbd_cmd_tid_i;
               bl_d    = wbd_cmd_bl_i;
               cnt_d   = (wbd_cmd_bl_i == '0) ? BL'(1) : wbd_cmd_bl_i;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               state_d = wbd_cmd_we_i ? WR : RD;
            end
         end
         RD: begin
            wbs_bry_o = !rspFull_q || wbd_res_rrdy_i;
            if (wbs_ack_i) begin
               rspLoad = 1'b1;
               loadDat = wbs_dat_i;
               cnt_d   = cnt_q - BL'(1);
               if (lastBeat) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         WR: begin
            wbs_bry_o = !rspFull_q || wbd_res_rrdy_i;
            if (wbs_ack_i) begin
               rspLoad = 1'b1;
               cnt_d   = cnt_q - BL'(1);
               if (lastBeat) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  state_d = (cnt_q > BL'(1)) ? DRAIN : IDLE;
               end else begin
                  wbd_cmd_wrdy_o = wbd_cmd_wval_i;
                  if (wbd_cmd_wval_i) begin
                     dat_d = wbd_cmd_dat_i;
                     sel_d = wbd_cmd_sel_i;
                  end else begin
                     state_d = WR_WAIT;
                  end
               end
            end
         end
         WR_WAIT: begin
            wbd_cmd_wrdy_o = 1'b1;
            if (wbd_cmd_wval_i) begin
               dat_d   = wbd_cmd_dat_i;
               sel_d   = wbd_cmd_sel_i;
               state_d = WR;
            end
         end
         DRAIN: begin
            wbd_cmd_wrdy_o = 1'b1;
            if (wbd_cmd_wval_i) begin
               cnt_d = cnt_q - BL'(1);
               if (cnt_q == BL'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rspLoad) begin
         rspFull_d = 1'b1;
         rspDat_d  = loadDat;
         rspAck_d  = 1'b1;
         rspLack_d = lastBeat;
         rspErr_d  = wbs_err_i;
         rspTid_d  = tid_q;
      end
   end

   // Registered outputs straight from the holding registers.
   always_comb begin
      wbs_cyc_o      = cyc_q;
      wbs_stb_o      = stb_q;
      wbs_we_o       = we_q;
      wbs_adr_o      = adr_q;
      wbs_dat_o      = dat_q;
      wbs_sel_o      = sel_q;
      wbs_bl_o       = bl_q;
      wbd_res_rval_o = rspFull_q;
      wbd_res_dat_o  = rspDat_q;
      wbd_res_ack_o  = rspAck_q;
      wbd_res_lack_o = rspLack_q;
      wbd_res_err_o  = rspErr_q;
      wbd_res_tid_o  = rspTid_q;
   end

endmodule

// File: tb/tb_wbi_slave_bridge.sv
// Testbench for wbi_slave_bridge: directed bursts followed by randomized
// bursts against a behavioural slave and an expected-response queue.
module tb_wbi_slave_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int BL = 10;

   typedef struct packed {
      logic [31:0] dat;
      logic        lack;
      logic        err;
      logic [3:0]  tid;
   } rsp_t;

   logic          mclk;
   logic          reset_n;
   logic          wbd_cmd_wval_i;
   logic          wbd_cmd_wrdy_o;
   logic [AW-1:0] wbd_cmd_adr_i;
   logic          wbd_cmd_we_i;
   logic [DW-1:0] wbd_cmd_dat_i;
   logic [BW-1:0] wbd_cmd_sel_i;
   logic [3:0]    wbd_cmd_tid_i;
   logic [BL-1:0] wbd_cmd_bl_i;
   logic          wbd_res_rval_o;
   logic          wbd_res_rrdy_i;
   logic [DW-1:0] wbd_res_dat_o;
   logic          wbd_res_ack_o;
   logic          wbd_res_lack_o;
   logic          wbd_res_err_o;
   logic [3:0]    wbd_res_tid_o;
   logic          wbs_cyc_o;
   logic          wbs_stb_o;
   logic          wbs_we_o;
   logic [AW-1:0] wbs_adr_o;
   logic [DW-1:0] wbs_dat_o;
   logic [BW-1:0] wbs_sel_o;
   logic [BL-1:0] wbs_bl_o;
   logic          wbs_bry_o;
   logic [DW-1:0] wbs_dat_i;
   logic          wbs_ack_i;
   logic          wbs_lack_i;
   logic          wbs_err_i;

   int compareCount = 0;
   int mismatchCount = 0;

   // Transaction description, owned by the main sequence
   logic          curWe;
   logic [31:0]   curAdr;
   logic [3:0]    curTid;
   int            curBlRaw;
   int            curBl;
   int            curErrBeat;
   logic [31:0]   wrDat [0:15];
   logic [3:0]    wrSel [0:15];
   int            ackPct;
   int            rrdyPct;
   logic          stallAfterFirst;
   logic          useForce;
   logic [31:0]   forceDat;
   int            txnBase;
   int            rspBase;
   int            ackBase;
   int            errBase;

   // Owned by the slave/monitor process
   rsp_t expQ[$];
   int   slaveBeats = 0;
   int   rspCount = 0;

   // Owned by the posedge observer
   int   ackCount = 0;
   int   errCount = 0;

   wbi_slave_bridge #(.AW(AW), .DW(DW), .BW(BW), .BL(BL)) dut (
      .mclk(mclk), .reset_n(reset_n),
      .wbd_cmd_wval_i(wbd_cmd_wval_i), .wbd_cmd_wrdy_o(wbd_cmd_wrdy_o),
      .wbd_cmd_adr_i(wbd_cmd_adr_i), .wbd_cmd_we_i(wbd_cmd_we_i),
      .wbd_cmd_dat_i(wbd_cmd_dat_i), .wbd_cmd_sel_i(wbd_cmd_sel_i),
      .wbd_cmd_tid_i(wbd_cmd_tid_i), .wbd_cmd_bl_i(wbd_cmd_bl_i),
      .wbd_res_rval_o(wbd_res_rval_o), .wbd_res_rrdy_i(wbd_res_rrdy_i),
      .wbd_res_dat_o(wbd_res_dat_o), .wbd_res_ack_o(wbd_res_ack_o),
      .wbd_res_lack_o(wbd_res_lack_o), .wbd_res_err_o(wbd_res_err_o),
      .wbd_res_tid_o(wbd_res_tid_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_bl_o(wbs_bl_o), .wbs_bry_o(wbs_bry_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
      .wbs_lack_i(wbs_lack_i), .wbs_err_i(wbs_err_i)
   );

   // Free-running clock
   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Counts acks and errors the bridge actually samples
   initial begin
      forever begin
         @(posedge mclk);
         if (reset_n && wbs_ack_i) begin
            ackCount++;
            if (wbs_err_i) errCount++;
         end
      end
   end

   // Response-ready driver with an optional 3-cycle stall after the first response
   initial begin
      int stallLeft;
      int stallMark;
      stallLeft = 0;
      stallMark = -1;
      wbd_res_rrdy_i = 1'b0;
      forever begin
         @(posedge mclk);
         #1;
         if (stallAfterFirst && rspCount == rspBase + 1 && stallMark != rspBase) begin
            stallMark = rspBase;
            stallLeft = 3;
         end
         if (stallLeft > 0) begin
            wbd_res_rrdy_i = 1'b0;
            stallLeft--;
         end else begin
            wbd_res_rrdy_i = ($urandom_range(99) < rrdyPct);
         end
      end
   end

   // Behavioural slave plus response monitor, both sampled on the falling edge
   initial begin
      rsp_t got;
      rsp_t held;
      rsp_t exp;
      rsp_t item;
      logic holdValid;
      logic endPending;
      logic isErr;
      logic isLast;
      logic [31:0] rdDat;
      int idx;
      holdValid = 1'b0;
      endPending = 1'b0;
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_lack_i = 1'b0;
      wbs_dat_i = '0;
      forever begin
         @(negedge mclk);
         wbs_ack_i = 1'b0;
         wbs_err_i = 1'b0;
         wbs_lack_i = 1'b0;
         if (!reset_n) begin
            expQ.delete();
            holdValid = 1'b0;
            endPending = 1'b0;
         end else begin
            got.dat = wbd_res_dat_o;
            got.lack = wbd_res_lack_o;
            got.err = wbd_res_err_o;
            got.tid = wbd_res_tid_o;
            if (holdValid) begin
               checkOutput("rspHeld", 64'(wbd_res_rval_o), 64'd1);
               checkOutput("rspStable", 64'(got), 64'(held));
            end
            if (wbd_res_rval_o && !wbd_res_rrdy_i)
               checkOutput("bryStall", 64'(wbs_bry_o), 64'd0);
            if (wbs_cyc_o && wbs_stb_o && !wbs_we_o && !wbd_res_rval_o)
               checkOutput("bryRead", 64'(wbs_bry_o), 64'd1);
            if (wbd_res_rval_o && wbd_res_rrdy_i) begin
               if (expQ.size() == 0) begin
                  checkOutput("rspExtra", 64'd1, 64'd0);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("rspFields", 64'(got), 64'(exp));
                  checkOutput("rspAck", 64'(wbd_res_ack_o), 64'd1);
               end
               rspCount++;
               holdValid = 1'b0;
            end else if (wbd_res_rval_o) begin
               holdValid = 1'b1;
               held = got;
            end else begin
               holdValid = 1'b0;
            end
            if (endPending) checkOutput("cycDrop", 64'(wbs_cyc_o), 64'd0);
            endPending = 1'b0;
            if (wbs_cyc_o && wbs_stb_o && wbs_bry_o && ($urandom_range(99) < ackPct)) begin
               idx = slaveBeats - txnBase;
               if (idx >= curBl || (curErrBeat >= 0 && idx > curErrBeat)) begin
                  checkOutput("extraBeat", 64'd1, 64'd0);
               end else begin
                  if (idx == 0) begin
                     checkOutput("slvAdr", 64'(wbs_adr_o), 64'(curAdr));
                     checkOutput("slvWe", 64'(wbs_we_o), 64'(curWe));
                     if (curBlRaw != 0) checkOutput("slvBl", 64'(wbs_bl_o), 64'(curBlRaw));
                  end
                  isErr = (idx == curErrBeat);
                  isLast = (idx == curBl - 1);
                  wbs_ack_i = 1'b1;
                  wbs_err_i = isErr;
                  wbs_lack_i = isLast;
                  if (curWe) begin
                     checkOutput("slvDat", 64'(wbs_dat_o), 64'(wrDat[idx]));
                     checkOutput("slvSel", 64'(wbs_sel_o), 64'(wrSel[idx]));
                     rdDat = '0;
                  end else begin
                     rdDat = useForce ? forceDat : $urandom;
                     wbs_dat_i = rdDat;
                  end
                  item.dat = rdDat;
                  item.lack = isLast || isErr;
                  item.err = isErr;
                  item.tid = curTid;
                  expQ.push_back(item);
                  endPending = isLast || isErr;
               end
               slaveBeats++;
            end
         end
      end
   end

   // Describe a new burst and snapshot the progress counters
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] tid,
                                input int blRaw, input int errBeat);
      curWe = we;
      curAdr = adr;
      curTid = tid;
      curBlRaw = blRaw;
      curBl = (blRaw == 0) ? 1 : blRaw;
      curErrBeat = errBeat;
      for (int i = 0; i < 16; i++) begin
         wrDat[i] = $urandom;
         wrSel[i] = 4'($urandom_range(15));
      end
      txnBase = slaveBeats;
      rspBase = rspCount;
      ackBase = ackCount;
      errBase = errCount;
   endtask

   // Present one command beat and wait (bounded) for its handshake
   task automatic sendBeat(input int k, output logic ok);
      wbd_cmd_wval_i = 1'b1;
      wbd_cmd_adr_i = (k == 0) ? curAdr : $urandom;
      wbd_cmd_we_i = curWe;
      wbd_cmd_dat_i = wrDat[k];
      wbd_cmd_sel_i = wrSel[k];
      wbd_cmd_tid_i = (k == 0) ? curTid : 4'($urandom_range(15));
      wbd_cmd_bl_i = (k == 0) ? BL'(curBlRaw) : BL'($urandom_range(15));
      ok = 1'b0;
      for (int w = 0; w < 200; w++) begin
         @(negedge mclk);
         #1;
         if (wbd_cmd_wrdy_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge mclk);
      #1;
      wbd_cmd_wval_i = 1'b0;
      if (!ok) checkOutput("cmdTimeout", 64'd0, 64'd1);
   endtask

   // Run one complete burst; gap < 0 picks a random 0..2 cycle gap per beat
   task automatic runBurst(input logic we, input logic [31:0] adr, input logic [3:0] tid,
                           input int blRaw, input int errBeat, input int gap);
      int nBeats;
      int nRsp;
      int g;
      logic ok;
      logic done;
      @(posedge mclk);
      #1;
      applyStimulus(we, adr, tid, blRaw, errBeat);
      nBeats = we ? curBl : 1;
      nRsp = (errBeat >= 0) ? errBeat + 1 : curBl;
      for (int k = 0; k < nBeats; k++) begin
         if (k > 0) begin
            g = (gap >= 0) ? gap : $urandom_range(2);
            for (int c = 0; c < g; c++) begin
               @(negedge mclk);
               #1;
               if (errCount - errBase > 0) begin
                  checkOutput("drainCyc", 64'(wbs_cyc_o), 64'd0);
                  checkOutput("drainRdy", 64'(wbd_cmd_wrdy_o), 64'd1);
               end else if (ackCount - ackBase == k) begin
                  checkOutput("wwBry", 64'(wbs_bry_o), 64'd0);
                  checkOutput("wwStb", 64'(wbs_stb_o), 64'd1);
                  checkOutput("wwRdy", 64'(wbd_cmd_wrdy_o), 64'd1);
               end
               @(posedge mclk);
               #1;
            end
         end
         sendBeat(k, ok);
         if (!ok) return;
         if (k == 0) begin
            @(negedge mclk);
            #1;
            checkOutput("cycRise", 64'({wbs_cyc_o, wbs_stb_o}), 64'd3);
            @(posedge mclk);
            #1;
         end
      end
      done = 1'b0;
      for (int w = 0; w < 400; w++) begin
         @(negedge mclk);
         #1;
         if (rspCount - rspBase == nRsp && !wbs_cyc_o) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput("burstDone", 64'(done), 64'd1);
      checkOutput("rspCount", 64'(rspCount - rspBase), 64'(nRsp));
      checkOutput("beatCount", 64'(slaveBeats - txnBase), 64'(nRsp));
   endtask

   // Main sequence: reset values, directed bursts, mid-burst reset, random bursts
   initial begin
      logic ok;
      logic seen;
      int bl;
      int eb;
      reset_n = 1'b0;
      wbd_cmd_wval_i = 1'b0;
      wbd_cmd_adr_i = '0;
      wbd_cmd_we_i = 1'b0;
      wbd_cmd_dat_i = '0;
      wbd_cmd_sel_i = '0;
      wbd_cmd_tid_i = '0;
      wbd_cmd_bl_i = '0;
      curWe = 1'b0; curAdr = '0; curTid = '0; curBlRaw = 1; curBl = 1; curErrBeat = -1;
      ackPct = 100; rrdyPct = 100; stallAfterFirst = 1'b0; useForce = 1'b0; forceDat = '0;
      txnBase = 0; rspBase = 0; ackBase = 0; errBase = 0;
      for (int i = 0; i < 16; i++) begin
         wrDat[i] = '0;
         wrSel[i] = '0;
      end

      repeat (3) @(posedge mclk);
      #2;
      checkOutput("rstWrdy", 64'(wbd_cmd_wrdy_o), 64'd1);
      checkOutput("rstBus", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_bry_o}), 64'd0);
      checkOutput("rstAdr", 64'(wbs_adr_o), 64'd0);
      checkOutput("rstDat", 64'(wbs_dat_o), 64'd0);
      checkOutput("rstSelBl", 64'({wbs_sel_o, wbs_bl_o}), 64'd0);
      checkOutput("rstRval", 64'(wbd_res_rval_o), 64'd0);
      checkOutput("rstRsp", 64'({wbd_res_dat_o, wbd_res_ack_o, wbd_res_lack_o, wbd_res_err_o, wbd_res_tid_o}), 64'd0);
      @(negedge mclk);
      reset_n = 1'b1;

      $display("[TB] single read");
      useForce = 1'b1;
      forceDat = 32'hDEADBEEF;
      runBurst(1'b0, 32'h100, 4'd3, 1, -1, 0);
      useForce = 1'b0;

      $display("[TB] read burst with response stall");
      stallAfterFirst = 1'b1;
      runBurst(1'b0, 32'h200, 4'd5, 4, -1, 0);
      stallAfterFirst = 1'b0;

      $display("[TB] write burst with beat gaps");
      runBurst(1'b1, 32'h300, 4'd7, 3, -1, 2);

      $display("[TB] write burst with error");
      runBurst(1'b1, 32'h400, 4'd9, 4, 1, 1);
      runBurst(1'b0, 32'h404, 4'd10, 2, -1, 0);

      $display("[TB] bl 0 read");
      runBurst(1'b0, 32'h500, 4'd11, 0, -1, 0);

      $display("[TB] reset during read burst");
      @(posedge mclk);
      #1;
      applyStimulus(1'b0, 32'h600, 4'd12, 4, -1);
      sendBeat(0, ok);
      seen = 1'b0;
      for (int w = 0; w < 100; w++) begin
         @(negedge mclk);
         #1;
         if (ackCount - ackBase >= 1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("firstAck", 64'(seen), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abortBus", 64'({wbs_cyc_o, wbs_stb_o, wbs_bry_o, wbd_res_rval_o}), 64'd0);
      checkOutput("abortRdy", 64'(wbd_cmd_wrdy_o), 64'd1);
      repeat (2) @(posedge mclk);
      @(negedge mclk);
      #2;
      reset_n = 1'b1;
      runBurst(1'b0, 32'h700, 4'd13, 2, -1, 0);

      $display("[TB] random bursts");
      for (int t = 0; t < 40; t++) begin
         ackPct = $urandom_range(40, 100);
         rrdyPct = $urandom_range(30, 100);
         bl = $urandom_range(0, 6);
         eb = -1;
         if ($urandom_range(4) == 0) eb = $urandom_range(0, ((bl == 0) ? 1 : bl) - 1);
         runBurst(1'($urandom_range(1)), $urandom, 4'($urandom_range(15)), bl, eb, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
